// File: rtl/video_timing_pkg.sv
// Shared constants, derived-total helpers and the status bundle carried
// through the output delay line.
package video_timing_pkg;

    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;

    // Syncs travel active-high internally; polarity is applied at the pins.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
        logic line_start;
        logic frame_start;
    } vt_status_t;

    function automatic int calc_h_total(input int disp, input int fp, input int sync, input int bp);
        return disp + fp + sync + bp;
    endfunction

    function automatic int calc_v_total(input int disp, input int fp, input int sync, input int bp);
        return disp + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth register delay line with synchronous clear to all-zero.
module sig_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
)(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel divider, x/y/frame counters, and
// sync/status decode delayed by PIPE+1 clocks.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   CLK_DIV   = DEF_CLK_DIV,
    parameter int   H_DISPLAY = DEF_H_DISPLAY,
    parameter int   H_FRONT   = DEF_H_FRONT,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BACK    = DEF_H_BACK,
    parameter int   V_DISPLAY = DEF_V_DISPLAY,
    parameter int   V_FRONT   = DEF_V_FRONT,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BACK    = DEF_V_BACK,
    parameter logic HSYNC_POL = POL_ACTIVE_LOW,
    parameter logic VSYNC_POL = POL_ACTIVE_LOW,
    parameter int   PIPE      = 0,
    parameter int   CW        = 10
)(
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_en,
    output logic          o_p_tick,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_video_on,
    output logic          o_line_start,
    output logic          o_frame_start,
    output logic [15:0]   o_frame_cnt
);

    localparam int H_TOTAL = calc_h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = calc_v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] X_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] X_DISP     = CW'(H_DISPLAY);
    localparam logic [CW-1:0] Y_DISP     = CW'(V_DISPLAY);
    localparam logic [CW-1:0] X_HS_FIRST = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] X_HS_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] Y_VS_FIRST = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] Y_VS_LAST  = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    if ((64'd1 << CW) < 64'(MAX_TOTAL)) begin : g_bad_cw
        $error("video_timing_gen: CW too narrow for the configured totals");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("video_timing_gen: CLK_DIV out of range 1..16");
    end
    if (PIPE < 0 || PIPE > 4) begin : g_bad_pipe
        $error("video_timing_gen: PIPE out of range 0..4");
    end

    logic [DW-1:0] r_div;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [15:0]   r_frame_cnt;
    logic          w_tick;
    logic          w_x_last;
    logic          w_y_last;
    vt_status_t    w_pre;
    vt_status_t    w_post;

    assign w_tick   = i_en && (r_div == '0);
    assign w_x_last = (r_x == X_LAST);
    assign w_y_last = (r_y == Y_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_frame_cnt <= '0;
        end else if (i_en) begin
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_x <= w_x_last ? '0 : r_x + 1'b1;
                if (w_x_last) begin
                    r_y <= w_y_last ? '0 : r_y + 1'b1;
                    if (w_y_last) r_frame_cnt <= r_frame_cnt + 16'd1;
                end
            end
        end
    end

    always_comb begin
        w_pre             = '0;
        w_pre.hsync       = (r_x >= X_HS_FIRST) && (r_x <= X_HS_LAST);
        w_pre.vsync       = (r_y >= Y_VS_FIRST) && (r_y <= Y_VS_LAST);
        w_pre.video_on    = (r_x < X_DISP) && (r_y < Y_DISP);
        w_pre.line_start  = w_tick && (r_x == '0);
        w_pre.frame_start = w_tick && (r_x == '0) && (r_y == '0);
    end

    sig_delay #(
        .WIDTH ($bits(vt_status_t)),
        .DEPTH (PIPE + 1)
    ) u_status_dly (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (w_pre),
        .o_q     (w_post)
    );

    assign o_p_tick      = w_tick;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_hsync       = HSYNC_POL ? w_post.hsync : ~w_post.hsync;
    assign o_vsync       = VSYNC_POL ? w_post.vsync : ~w_post.vsync;
    assign o_video_on    = w_post.video_on;
    assign o_line_start  = w_post.line_start;
    assign o_frame_start = w_post.frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized en/reset stimulus against a pixel-count reference model.
module tb_video_timing_gen;

    localparam int   DIV  = 3;
    localparam int   PIPE = 2;
    localparam int   HD = 8, HF = 2, HS = 2, HB = 2;
    localparam int   VD = 4, VF = 1, VS = 1, VB = 1;
    localparam int   CW = 4;
    localparam logic HPOL = 1'b1;
    localparam logic VPOL = 1'b0;
    localparam int   HT = HD + HF + HS + HB;
    localparam int   VT = VD + VF + VS + VB;
    localparam int   FP = HT * VT;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b1;
    logic          p_tick;
    logic [CW-1:0] x, y;
    logic          hsync, vsync, video_on, line_start, frame_start;
    logic [15:0]   frame_cnt;

    video_timing_gen #(
        .CLK_DIV(DIV), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .PIPE(PIPE), .CW(CW)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_en(en), .o_p_tick(p_tick),
        .o_x(x), .o_y(y), .o_hsync(hsync), .o_vsync(vsync),
        .o_video_on(video_on), .o_line_start(line_start),
        .o_frame_start(frame_start), .o_frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    // Model: c = enabled clocks since reset; pixels ticked = ceil(c/DIV).
    int c = 0;
    int frm_adj = 0;
    // Expected delay-line contents, active-sense {hs, vs, von, ls, fs}.
    logic [4:0] hist [0:PIPE];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 20) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pix_n();
        return (c + DIV - 1) / DIV;
    endfunction

    task automatic check_outputs();
        int n;
        n = pix_n();
        chk("p_tick", 32'(p_tick), 32'(en && (c % DIV == 0)));
        chk("x", 32'(x), n % HT);
        chk("y", 32'(y), (n / HT) % VT);
        chk("frame_cnt", 32'(frame_cnt), (frm_adj + n / FP) & 32'hFFFF);
        chk("hsync", 32'(hsync), 32'(hist[PIPE][4] ? HPOL : !HPOL));
        chk("vsync", 32'(vsync), 32'(hist[PIPE][3] ? VPOL : !VPOL));
        chk("video_on", 32'(video_on), 32'(hist[PIPE][2]));
        chk("line_start", 32'(line_start), 32'(hist[PIPE][1]));
        chk("frame_start", 32'(frame_start), 32'(hist[PIPE][0]));
    endtask

    // Advance the model across the upcoming rising edge using current inputs.
    task automatic edge_model();
        int n, px, py;
        logic tick;
        logic [4:0] pre;
        n    = pix_n();
        px   = n % HT;
        py   = (n / HT) % VT;
        tick = en && (c % DIV == 0);
        pre[4] = (px >= HD + HF) && (px < HD + HF + HS);
        pre[3] = (py >= VD + VF) && (py < VD + VF + VS);
        pre[2] = (px < HD) && (py < VD);
        pre[1] = tick && (px == 0);
        pre[0] = tick && (px == 0) && (py == 0);
        if (reset) begin
            c = 0;
            frm_adj = 0;
            for (int i = 0; i <= PIPE; i++) hist[i] = '0;
        end else begin
            for (int i = PIPE; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = pre;
            if (en) c++;
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        edge_model();
        for (int cyc = 0; cyc < 3500; cyc++) begin
            @(negedge clk);
            check_outputs();
            reset = (cyc < 2) || (cyc == 3000) || ($urandom_range(0, 599) == 0);
            en    = ($urandom_range(0, 99) < 85);
            if (cyc >= 700 && cyc < 737) en = 1'b0;
            if (cyc == 1000 || cyc == 2000) begin
                force dut.r_frame_cnt = (cyc == 1000) ? 16'hFFFE : 16'hFFFF;
                release dut.r_frame_cnt;
                frm_adj = ((cyc == 1000) ? 32'hFFFE : 32'hFFFF) - pix_n() / FP;
            end
            edge_model();
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
